// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: PC, imem req/gnt/rvalid port, hold buffer, IF/ID.
// Optional macro IFU_PERF_CNT_EN adds fetch/kill performance counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_INC   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_jump,
  input  logic [31:0] pc_jump_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_kill_cnt
`endif
);

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'(PC_INC);

  typedef enum logic {
    S_REQ,
    S_WAIT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        kill;
  logic        hold_valid;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic        take;
  logic        rsp;
  logic        drop;
  logic        accept;
  logic [31:0] jump_addr;

  assign imem_addr = pc;
  assign jump_addr = {pc_jump_addr[31:2], 2'b00};
  assign take      = imem_req & imem_gnt;
  assign rsp       = (state == S_WAIT) & imem_rvalid;
  assign drop      = rsp & (kill | pc_jump);
  assign accept    = rsp & ~drop;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  // next state and request; no new request while the hold buffer is full
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    unique case (state)
      S_REQ: begin
        imem_req = ~hold_valid & ~rst;
        if (imem_req && imem_gnt) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // PC advances on grant; a redirect overrides
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pc <= RESET_PC;
    else if (pc_jump) pc <= jump_addr;
    else if (take)    pc <= pc + PC_STEP;
  end

  // address of the outstanding request
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       req_pc <= RESET_PC;
    else if (take) req_pc <= imem_addr;
  end

  // kill marks an in-flight response that belongs to the old path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kill <= 1'b0;
    end else if (pc_jump &&
                 (take || (state == S_WAIT && !imem_rvalid))) begin
      kill <= 1'b1;
    end else if (rsp) begin
      kill <= 1'b0;
    end
  end

  // IF/ID register and hold buffer; redirect flushes, stall parks responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid  <= 1'b0;
      hold_pc     <= 32'h0;
      hold_inst   <= NOP;
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'h0;
      if_id_inst  <= NOP;
    end else if (pc_jump) begin
      hold_valid  <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP;
    end else if (stall) begin
      if (accept) begin
        hold_valid <= 1'b1;
        hold_pc    <= req_pc;
        hold_inst  <= imem_rdata;
      end
    end else if (hold_valid) begin
      if_id_valid <= 1'b1;
      if_id_pc    <= hold_pc;
      if_id_inst  <= hold_inst;
      hold_valid  <= accept;
      if (accept) begin
        hold_pc   <= req_pc;
        hold_inst <= imem_rdata;
      end
    end else if (accept) begin
      if_id_valid <= 1'b1;
      if_id_pc    <= req_pc;
      if_id_inst  <= imem_rdata;
    end else begin
      if_id_valid <= 1'b0;
    end
  end

`ifdef IFU_PERF_CNT_EN
  // count delivered and discarded responses, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_kill_cnt  <= 32'h0;
    end else begin
      if (accept) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (drop)   perf_kill_cnt  <= perf_kill_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed phases, then random stall/redirect/memory
// timing scored against a program-order instruction stream model.
`timescale 1ns/1ps
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_jump = 1'b0;
  logic [31:0] pc_jump_addr = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_kill_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cy       = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .pc_jump      (pc_jump),
    .pc_jump_addr (pc_jump_addr),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_id_valid  (if_id_valid),
    .if_id_pc     (if_id_pc),
`ifdef IFU_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_kill_cnt  (perf_kill_cnt),
`endif
    .if_id_inst   (if_id_inst)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // memory: grant after gnt_lat cycles of request, respond rv_lat cycles later
  int          gnt_lat = 0;
  int          rv_lat = 1;
  bit          rand_mem = 1'b0;
  bit          hold_on_rst = 1'b0;
  int          age = 0;
  bit          busy = 1'b0;
  int          rv_cnt = 0;
  logic [31:0] busy_addr = 32'h0;

  always @(posedge clk) begin
    #2;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (rst && !hold_on_rst) begin
      busy = 1'b0;
      age  = 0;
    end else begin
      if (busy) begin
        if (rv_cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = word_at(busy_addr);
          busy        = 1'b0;
        end else begin
          rv_cnt--;
        end
      end
      if (imem_req && !busy) begin
        if (rand_mem ? ($urandom_range(1, 0) == 1) : (age >= gnt_lat)) begin
          imem_gnt  = 1'b1;
          busy      = 1'b1;
          busy_addr = imem_addr;
          age       = 0;
          rv_cnt    = rand_mem ? int'($urandom_range(3, 1)) : rv_lat;
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
    end
  end

  // stream model: ID consumes sequential PCs; a redirect restarts the stream
  logic [31:0] exp_pc = 32'h0;
  int          consumed = 0;
  logic        p_req = 1'b0;
  logic        p_gnt = 1'b0;
  logic        p_jump = 1'b0;
  logic        p_rst = 1'b1;
  logic [31:0] p_addr = 32'h0;

  always @(negedge clk) begin
    if (rst) begin
      exp_pc = 32'h0;
    end else begin
      if (p_req && !p_gnt && !p_jump && !p_rst) begin
        chk1("req_held", imem_req, 1'b1);
        chk("addr_held", imem_addr, p_addr);
      end
      if (if_id_valid && !stall && !pc_jump) begin
        chk("stream_pc", if_id_pc, exp_pc);
        chk("stream_inst", if_id_inst, word_at(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (pc_jump) exp_pc = pc_jump_addr & 32'hFFFF_FFFC;
    end
    p_req  = imem_req;
    p_gnt  = imem_gnt;
    p_jump = pc_jump;
    p_rst  = rst;
    p_addr = imem_addr;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    cy++;
  endtask

  task automatic goto_cy(input int k);
    while (cy < k) cyc();
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    stall        = 1'b0;
    pc_jump      = 1'b0;
    pc_jump_addr = 32'h0;
    repeat (2) cyc();
    rst = 1'b0;
    cy  = 0;
  endtask

  int c0;

  initial begin
    // reset values
    smp();
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk1("rst_valid", if_id_valid, 1'b0);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_inst", if_id_inst, NOP);

    // A: sequential fetch, 1-cycle grant and response
    do_reset();
    smp();
    chk1("a_req0", imem_req, 1'b1);
    chk("a_addr0", imem_addr, 32'h0);
    goto_cy(2); smp();
    chk1("a_v0", if_id_valid, 1'b1);
    chk("a_pc0", if_id_pc, 32'h0);
    chk("a_inst0", if_id_inst, word_at(32'h0));
    chk("a_addr4", imem_addr, 32'h4);
    goto_cy(3); smp();
    chk1("a_gap", if_id_valid, 1'b0);
    goto_cy(4); smp();
    chk1("a_v4", if_id_valid, 1'b1);
    chk("a_pc4", if_id_pc, 32'h4);
    chk("a_inst4", if_id_inst, word_at(32'h4));
    chk("a_addr8", imem_addr, 32'h8);

    // B: redirect while waiting for 0x8 kills that response
    rv_lat = 2;
    do_reset();
    goto_cy(7);
    pc_jump = 1'b1; pc_jump_addr = 32'h0000_0101;
    goto_cy(8);
    pc_jump = 1'b0;
    smp();
    chk1("b_v_flush", if_id_valid, 1'b0);
    chk("b_inst_nop", if_id_inst, NOP);
    chk1("b_req_wait", imem_req, 1'b0);
    goto_cy(9); smp();
    chk1("b_v_kill", if_id_valid, 1'b0);
    chk1("b_req_tgt", imem_req, 1'b1);
    chk("b_addr_tgt", imem_addr, 32'h100);
    goto_cy(12); smp();
    chk1("b_v_tgt", if_id_valid, 1'b1);
    chk("b_pc_tgt", if_id_pc, 32'h100);
    chk("b_inst_tgt", if_id_inst, word_at(32'h100));

    // C: stall over the 0x4 response fills the hold buffer
    rv_lat = 1;
    do_reset();
    goto_cy(2);
    stall = 1'b1;
    goto_cy(4); smp();
    chk1("c_req_hold", imem_req, 1'b0);
    chk1("c_v0", if_id_valid, 1'b1);
    chk("c_pc0", if_id_pc, 32'h0);
    goto_cy(5);
    stall = 1'b0;
    smp();
    chk1("c_req_drain", imem_req, 1'b0);
    chk("c_pc0_b", if_id_pc, 32'h0);
    goto_cy(6); smp();
    chk("c_pc4", if_id_pc, 32'h4);
    chk("c_inst4", if_id_inst, word_at(32'h4));
    chk1("c_req8", imem_req, 1'b1);
    chk("c_addr8", imem_addr, 32'h8);

    // D: redirect and stall together with the hold buffer full
    do_reset();
    goto_cy(2);
    stall = 1'b1;
    goto_cy(4);
    pc_jump = 1'b1; pc_jump_addr = 32'h200;
    goto_cy(5);
    pc_jump = 1'b0; stall = 1'b0;
    smp();
    chk1("d_v_flush", if_id_valid, 1'b0);
    chk("d_inst_nop", if_id_inst, NOP);
    chk1("d_req", imem_req, 1'b1);
    chk("d_addr", imem_addr, 32'h200);
    goto_cy(6); smp();
    chk1("d_hold_gone", if_id_valid, 1'b0);
    goto_cy(7); smp();
    chk1("d_v_tgt", if_id_valid, 1'b1);
    chk("d_pc_tgt", if_id_pc, 32'h200);

    // E: slow grant; request stays put, redirect moves the address
    gnt_lat = 5;
    do_reset();
    goto_cy(1); smp();
    chk1("e_req1", imem_req, 1'b1);
    chk("e_addr1", imem_addr, 32'h0);
    goto_cy(2);
    pc_jump = 1'b1; pc_jump_addr = 32'h300;
    smp();
    chk("e_addr2", imem_addr, 32'h0);
    goto_cy(3);
    pc_jump = 1'b0;
    smp();
    chk1("e_req3", imem_req, 1'b1);
    chk("e_addr3", imem_addr, 32'h300);
    goto_cy(5); smp();
    chk1("e_gnt5", imem_gnt, 1'b1);
    chk("e_addr5", imem_addr, 32'h300);
    goto_cy(7); smp();
    chk("e_pc_tgt", if_id_pc, 32'h300);
    gnt_lat = 0;

    // F: reset while waiting; the late response is ignored
    rv_lat = 4;
    do_reset();
    hold_on_rst = 1'b1;
    goto_cy(10); smp();
    chk("f_pc4", if_id_pc, 32'h4);
    goto_cy(11);
    rst = 1'b1;
    smp();
    chk1("f_rst_req", imem_req, 1'b0);
    chk("f_rst_addr", imem_addr, 32'h0);
    chk1("f_rst_valid", if_id_valid, 1'b0);
    chk("f_rst_pc", if_id_pc, 32'h0);
    chk("f_rst_inst", if_id_inst, NOP);
    goto_cy(12);
    rst = 1'b0;
    rv_lat = 1;
    smp();
    chk1("f_req_restart", imem_req, 1'b1);
    chk("f_addr_restart", imem_addr, 32'h0);
    goto_cy(15); smp();
    chk1("f_late_ignored", if_id_valid, 1'b0);
    goto_cy(16); smp();
    chk1("f_v0", if_id_valid, 1'b1);
    chk("f_pc0", if_id_pc, 32'h0);
    chk("f_inst0", if_id_inst, word_at(32'h0));
    hold_on_rst = 1'b0;

    // R: random memory timing, stalls and redirects (some near the wrap)
    rand_mem = 1'b1;
    do_reset();
    c0 = consumed;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      stall   = ($urandom_range(3, 0) == 0);
      pc_jump = ($urandom_range(19, 0) == 0);
      pc_jump_addr = ($urandom_range(3, 0) == 0) ?
                     (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) :
                     $urandom;
    end
    cyc();
    stall   = 1'b0;
    pc_jump = 1'b0;
    smp();
    chk1("r_progress", (consumed - c0) > 150, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the in-order RV32I core. It sits directly downstream of the branch/jump detection logic: it consumes `pc_jump` / `pc_jump_addr` (redirect) and `stall`.
- Owns the PC register, drives a single-outstanding request/grant/response interface to instruction memory, and produces the IF/ID pipeline register.
- A 1-entry hold buffer absorbs a response that returns while the pipeline is stalled.

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `PC_INC`, default 4: PC increment per sequential fetch (bytes).

Ports:
- `clk`  input  1  core clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `pc_jump`  input  1  redirect request (branch taken / jal / jalr); also acts as the flush.
- `pc_jump_addr`  input  32  redirect target.
- `stall`  input  1  hold the IF/ID register and stop consuming responses.
- `imem_req`  output  1  fetch request valid.
- `imem_addr`  output  32  fetch address (word aligned).
- `imem_gnt`  input  1  request accepted this cycle.
- `imem_rvalid`  input  1  response data valid; at most one per granted request, no earlier than 1 cycle after grant.
- `imem_rdata`  input  32  fetched instruction.
- `if_id_valid`  output  1  IF/ID holds a live instruction.
- `if_id_pc`  output  32  PC of the IF/ID instruction.
- `if_id_inst`  output  32  IF/ID instruction word.

Behaviour:
- Reset (async, immediate):
  - `pc`=`RESET_PC`; state=S_REQ; `imem_req`=0 during reset, and `imem_addr`=`RESET_PC`.
  - `if_id_valid`=0, `if_id_pc`=0, `if_id_inst`=32'h0000_0013 (nop).
  - Hold buffer empty; kill flag=0.
  - First request is raised in the first cycle after `rst` deasserts.
- FSM states:
  - S_REQ:
    - `imem_req`=1 when the hold buffer is empty; `imem_addr`=`pc`.
    - On `imem_gnt`: record `req_pc`=`imem_addr`, `pc`<=`pc`+`PC_INC`, go to S_WAIT.
  - S_WAIT:
    - `imem_req`=0.
    - On `imem_rvalid`: deliver or discard the response (rules below), then go to S_REQ.
- Handshake rules:
  - Once raised, `imem_req` stays high until granted.
  - `imem_addr` is stable while ungranted. Sole exception: a redirect, which changes it the next cycle.
  - Only one request is outstanding at any time.
- Response delivery (unkilled `imem_rvalid`):
  - `stall`=0 and hold buffer empty: IF/ID <= {1, `req_pc`, `imem_rdata`}.
  - `stall`=1: hold buffer <= {`req_pc`, `imem_rdata`}; IF/ID unchanged.
- IF/ID update when `stall`=0 and there is no redirect:
  - If the hold buffer is full, IF/ID <= hold buffer and the hold buffer empties.
  - Otherwise, if a response arrives, load it.
  - Otherwise `if_id_valid`<=0.
- Stall with hold buffer full: no new request is raised. A request already raised is held per the handshake rules; its grant is still taken.
- Redirect (`pc_jump`=1), which has priority over `stall`:
  - `pc`<=`pc_jump_addr`; `if_id_valid`<=0, `if_id_inst`<=nop; hold buffer cleared.
  - In S_WAIT, or in S_REQ with `imem_gnt` the same cycle: kill flag<=1. The next `imem_rvalid` is discarded and clears the kill flag.
  - An `imem_rvalid` in the same cycle as `pc_jump` is discarded.
  - The first request to the target is issued in the cycle after the redirect, unless it must wait for a killed response.
- Arithmetic: PC adds wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0). `pc_jump_addr` bits [1:0] are forced to 0.
- Latency: redirect to first `imem_req` at the target is 1 cycle. Grant to IF/ID valid is 1 cycle after `imem_rvalid`.

Optional Feature:
- Macro `IFU_PERF_CNT_EN`.
- Defined: adds outputs `perf_fetch_cnt[31:0]` and `perf_kill_cnt[31:0]`, both reset to 0.
  - `perf_fetch_cnt` increments on each delivered, unkilled response.
  - `perf_kill_cnt` increments on each discarded response.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory with 1-cycle grant and 1-cycle `rvalid`: `imem_addr` sequence 0x0, 0x4, 0x8; IF/ID shows pc 0x0 with its instruction, then 0x4, in order; `if_id_valid` is 0 in gap cycles.
- `pc_jump`=1, `pc_jump_addr`=0x100 while in S_WAIT for 0x8: the 0x8 response is discarded, `if_id_valid`=0, next `imem_addr`=0x100.
- `stall`=1 held 3 cycles while the 0x4 response arrives: IF/ID holds the 0x0 entry, the hold buffer captures 0x4, no new `imem_req`; after `stall`=0, IF/ID=0x4, then a request for 0x8 follows.
- `pc_jump` and `stall` asserted together with the hold buffer full: hold buffer cleared, IF/ID invalid, next fetch at `pc_jump_addr`.
- `imem_gnt` delayed 5 cycles: `imem_req` and `imem_addr` stay stable throughout; a redirect in cycle 3 moves `imem_addr` to the target the next cycle.
- `rst` asserted mid-S_WAIT: outputs return to reset values immediately; a late `imem_rvalid` after release is ignored; fetch restarts at `RESET_PC`.
